ex_div_unit: RTL and testbench



---
 rtl/ex_div_unit.sv | 157 +++++++++++++++
 tb/tb_ex_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// EX-stage radix-2 restoring divider for DIV/DIVU.
// Writes {remainder, quotient} to HI/LO and stalls the pipeline while busy.
module ex_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   quo, quo_n;
  logic [DATA_W-1:0]   dvs, dvs_n;
  logic [DATA_W-1:0]   rem, rem_n;
  logic                neg_q, neg_q_n;
  logic                neg_r, neg_r_n;
  logic [2*DATA_W-1:0] result_n;
  logic                ready_n;

  logic [DATA_W:0]     sh;
  logic                ge;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic                last;

  // quo holds the not-yet-consumed dividend bits and collects quotient bits
  assign sh       = {rem, quo[DATA_W-1]};
  assign ge       = sh >= {1'b0, dvs};
  assign diff     = sh[DATA_W-1:0] - dvs;
  assign quo_step = {quo[DATA_W-2:0], ge};
  assign rem_step = ge ? diff : sh[DATA_W-1:0];
  assign last     = cnt == CNT_W'(DATA_W - 1);

  assign mag1 = opdata1_i[DATA_W-1] ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = opdata2_i[DATA_W-1] ? (~opdata2_i + 1'b1) : opdata2_i;

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      rem      <= rem_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    quo_n    = quo;
    dvs_n    = dvs;
    rem_n    = rem;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result_o;
    ready_n  = ready_o;
    unique case (state)
      S_FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = S_BYZERO;
          end else begin
            state_n = S_ON;
            cnt_n   = '0;
            rem_n   = '0;
            if (signed_div_i) begin
              quo_n   = mag1;
              dvs_n   = mag2;
              neg_q_n = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
              neg_r_n = opdata1_i[DATA_W-1];
            end else begin
              quo_n   = opdata1_i;
              dvs_n   = opdata2_i;
              neg_q_n = 1'b0;
              neg_r_n = 1'b0;
            end
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_n = S_FREE;
          cnt_n   = '0;
        end else begin
          state_n = S_END;
          quo_n   = '0;
          rem_n   = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_n = S_FREE;
          cnt_n   = '0;
        end else if (last) begin
          state_n = S_END;
          cnt_n   = '0;
          quo_n   = neg_q ? (~quo_step + 1'b1) : quo_step;
          rem_n   = neg_r ? (~rem_step + 1'b1) : rem_step;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          quo_n = quo_step;
          rem_n = rem_step;
        end
      end
      S_END: begin
        // held start keeps the result visible until EX moves on
        if (start_i) begin
          ready_n  = 1'b1;
          result_n = {rem, quo};
        end else begin
          state_n  = S_FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end
      default: state_n = S_FREE;
    endcase
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table plus annul
// and asynchronous-reset sequences.
module tb_ex_div_unit;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_result(input string name, input logic [63:0] exp,
                             input int lat, input bit scramble);
    int n = 0;
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (stallreq_o) n++;
      if (scramble && i == 2) begin
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'h0;
        signed_div_i = ~signed_div_i;
      end
    end
    chk({name, " ready"}, 64'(got), 64'd1);
    chk({name, " stall cycles"}, 64'(n), 64'(lat));
    chk({name, " result"}, result_o, exp);
    chk({name, " stall in ready"}, 64'(stallreq_o), 64'd0);
  endtask

  task automatic run_div(input vec_t v);
    @(negedge clk);
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    wait_result(v.name, v.exp, v.lat, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk({v.name, " hold ready"}, 64'(ready_o), 64'd1);
      chk({v.name, " hold result"}, result_o, v.exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " drop ready"}, 64'(ready_o), 64'd0);
    chk({v.name, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    vecs.push_back('{"divu 100/7", 1'b0, 32'd100, 32'd7,
                     {32'd2, 32'd14}, 33});
    vecs.push_back('{"div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                     {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33});
    vecs.push_back('{"div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                     {32'h0000_0001, 32'hFFFF_FFFD}, 33});
    vecs.push_back('{"divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2});
    vecs.push_back('{"div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                     {32'h0, 32'h8000_0000}, 33});
    vecs.push_back('{"divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1,
                     {32'h0, 32'hFFFF_FFFF}, 33});
    vecs.push_back('{"divu 0/5", 1'b0, 32'd0, 32'd5, 64'd0, 33});
    vecs.push_back('{"div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     {32'hFFFF_FFFE, 32'h0000_000E}, 33});
    vecs.push_back('{"divu big/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                     {32'h8000_0000, 32'h0}, 33});
    vecs.push_back('{"div 0/0", 1'b1, 32'd0, 32'd0, 64'd0, 2});

    #12;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_div(vecs[i]);

    // annul at ON cycle 10, then restart with 9/3
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    chk("annul ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("annul no result", 64'(seen), 64'd0);
    run_div('{"divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33});

    // asynchronous reset mid-ON, restart with start held
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst on ready", 64'(ready_o), 64'd0);
    chk("rst on result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_result("rst restart", {32'd2, 32'd14}, 33, 1'b0);

    // asynchronous reset while the result is showing
    #3;
    rst = 1'b0;
    #1;
    chk("rst end ready", 64'(ready_o), 64'd0);
    chk("rst end result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle ready", 64'(ready_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
